// File: rtl/operand_fwd_ctrl.sv
// operand_fwd_ctrl: registered EX operand-select codes, load-use stall and memory-wait freeze
module operand_fwd_ctrl #(
  parameter int REG_W   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic             id_use_imm,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_wen,
  input  logic             id_is_load,
  input  logic             flush,
  input  logic             mem_ready,
  output logic [1:0]       sel_a_ex,
  output logic [1:0]       sel_b_ex,
  output logic             stall_id,
  output logic             bubble_ex,
  output logic             freeze,
  output logic             mem_timeout
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {RUN, LU_STALL, MEM_WAIT} state_t;
  typedef struct packed {
    logic             v;
    logic [REG_W-1:0] rd;
    logic             wen;
    logic             ld;
  } slot_t;
  state_t        state, state_nx;
  slot_t         exs, mems;
  logic [CW-1:0] cnt;
  logic          ex_a, ex_b, mem_a, mem_b, hazard, mem_wait;
  logic [1:0]    sel_a_nx, sel_b_nx;
  always_comb begin
    ex_a     = exs.v && exs.wen && exs.rd == id_rs1 && id_rs1 != '0 && id_rs1_used;
    ex_b     = exs.v && exs.wen && exs.rd == id_rs2 && id_rs2 != '0 && id_rs2_used;
    mem_a    = mems.v && mems.wen && mems.rd == id_rs1 && id_rs1 != '0 && id_rs1_used;
    mem_b    = mems.v && mems.wen && mems.rd == id_rs2 && id_rs2 != '0 && id_rs2_used;
    hazard   = id_valid && exs.ld && (ex_a || ex_b);
    mem_wait = mems.v && mems.ld && !mem_ready;
    sel_a_nx = ex_a ? 2'b01 : mem_a ? 2'b10 : 2'b00;
    sel_b_nx = id_use_imm ? 2'b11 : ex_b ? 2'b01 : mem_b ? 2'b10 : 2'b00;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) state <= RUN;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = (state == MEM_WAIT) ? (mem_ready ? RUN : MEM_WAIT) :
               mem_wait ? MEM_WAIT :
               (state == RUN && hazard && !flush) ? LU_STALL : RUN;
  end
  // freeze follows the wait condition in every state so a slow load never slips out of MEM
  always_comb begin
    freeze    = mem_wait;
    stall_id  = state == RUN && hazard && !flush && !mem_wait;
    bubble_ex = stall_id;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      exs         <= '0;
      mems        <= '0;
      sel_a_ex    <= 2'b00;
      sel_b_ex    <= 2'b00;
      cnt         <= '0;
      mem_timeout <= 1'b0;
    end else begin
      if (!freeze) begin
        mems     <= exs;
        exs      <= {id_valid && !bubble_ex && !flush, id_rd, id_wen, id_is_load};
        sel_a_ex <= (bubble_ex || flush) ? 2'b00 : sel_a_nx;
        sel_b_ex <= (bubble_ex || flush) ? 2'b00 : sel_b_nx;
      end
      cnt         <= !freeze ? '0 : (cnt == CW'(TIMEOUT)) ? cnt : cnt + CW'(1);
      mem_timeout <= mem_timeout || (freeze && cnt >= CW'(TIMEOUT - 1));
    end
  end
endmodule

// File: tb/tb_operand_fwd_ctrl.sv
// tb_operand_fwd_ctrl: table-driven directed vectors for the forwarding/stall controller
module tb_operand_fwd_ctrl;
  typedef struct {
    int rst, v, rs1, u1, rs2, u2, imm, rd, wen, ld, fl, mr;
    int st, fz, sa, sb, to;
  } vec_t;
  logic       clk = 1'b0;
  logic       rst_n, id_valid, id_rs1_used, id_rs2_used, id_use_imm, id_wen, id_is_load, flush, mem_ready;
  logic [3:0] id_rs1, id_rs2, id_rd;
  logic [1:0] sel_a_ex, sel_b_ex;
  logic       stall_id, bubble_ex, freeze, mem_timeout;
  int         passed = 0, total = 0;
  vec_t       tv[37];
  vec_t       hs[9];
  operand_fwd_ctrl #(.REG_W(4), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_use_imm(id_use_imm),
    .id_rd(id_rd), .id_wen(id_wen), .id_is_load(id_is_load), .flush(flush),
    .mem_ready(mem_ready), .sel_a_ex(sel_a_ex), .sel_b_ex(sel_b_ex), .stall_id(stall_id),
    .bubble_ex(bubble_ex), .freeze(freeze), .mem_timeout(mem_timeout)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int idx, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s vec %0d: got %0d, expected %0d", name, idx, act, exp);
  endtask
  task automatic apply(input vec_t t, input int idx);
    rst_n       = 1'(t.rst);
    id_valid    = 1'(t.v);
    id_rs1      = 4'(t.rs1);
    id_rs1_used = 1'(t.u1);
    id_rs2      = 4'(t.rs2);
    id_rs2_used = 1'(t.u2);
    id_use_imm  = 1'(t.imm);
    id_rd       = 4'(t.rd);
    id_wen      = 1'(t.wen);
    id_is_load  = 1'(t.ld);
    flush       = 1'(t.fl);
    mem_ready   = 1'(t.mr);
    #4;
    if (t.rst != 0) begin
      chk("stall_id", idx, int'(stall_id), t.st);
      chk("bubble_ex", idx, int'(bubble_ex), t.st);
      chk("freeze", idx, int'(freeze), t.fz);
    end
    @(posedge clk);
    #1;
    chk("sel_a_ex", idx, int'(sel_a_ex), t.sa);
    chk("sel_b_ex", idx, int'(sel_b_ex), t.sb);
    chk("mem_timeout", idx, int'(mem_timeout), t.to);
  endtask
  initial begin
    //      rst v rs1 u1 rs2 u2 imm rd wen ld fl mr   st fz sa sb to
    tv = '{
      '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0},
      '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0},
      '{1, 1, 1, 1, 2, 1, 0, 3, 1, 0, 0, 1,  0, 0, 0, 0, 0},
      '{1, 1, 3, 1, 4, 1, 0, 8, 1, 0, 0, 1,  0, 0, 1, 0, 0},
      '{1, 1, 1, 1, 2, 1, 0, 3, 1, 0, 0, 1,  0, 0, 0, 0, 0},
      '{1, 1, 5, 1, 3, 1, 0, 10, 1, 0, 0, 1, 0, 0, 0, 1, 0},
      '{1, 1, 1, 1, 2, 1, 0, 5, 1, 0, 0, 1,  0, 0, 0, 0, 0},
      '{1, 1, 1, 1, 2, 1, 0, 11, 1, 0, 0, 1, 0, 0, 0, 0, 0},
      '{1, 1, 5, 1, 6, 1, 0, 12, 1, 0, 0, 1, 0, 0, 2, 0, 0},
      '{1, 1, 1, 1, 2, 1, 0, 0, 1, 0, 0, 1,  0, 0, 0, 0, 0},
      '{1, 1, 0, 1, 0, 1, 0, 13, 1, 0, 0, 1, 0, 0, 0, 0, 0},
      '{1, 1, 1, 1, 2, 1, 0, 7, 1, 0, 0, 1,  0, 0, 0, 0, 0},
      '{1, 1, 1, 1, 2, 1, 0, 7, 1, 0, 0, 1,  0, 0, 0, 0, 0},
      '{1, 1, 7, 1, 7, 1, 1, 14, 1, 0, 0, 1, 0, 0, 1, 3, 0},
      '{1, 1, 7, 1, 7, 1, 0, 15, 1, 0, 0, 1, 0, 0, 2, 2, 0},
      '{1, 1, 15, 0, 14, 0, 0, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0},
      '{1, 1, 1, 1, 0, 0, 0, 2, 1, 1, 0, 1,  0, 0, 1, 0, 0},
      '{1, 1, 2, 1, 3, 1, 0, 4, 1, 0, 0, 1,  1, 0, 0, 0, 0},
      '{1, 1, 2, 1, 3, 1, 0, 4, 1, 0, 0, 1,  0, 0, 2, 0, 0},
      '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0},
      '{1, 1, 0, 0, 0, 0, 0, 2, 1, 1, 0, 1,  0, 0, 0, 0, 0},
      '{1, 1, 2, 1, 0, 0, 0, 4, 1, 0, 1, 1,  0, 0, 0, 0, 0},
      '{1, 1, 4, 1, 0, 0, 0, 5, 1, 0, 0, 1,  0, 0, 0, 0, 0},
      '{1, 1, 0, 0, 0, 0, 0, 6, 1, 1, 0, 1,  0, 0, 0, 0, 0},
      '{1, 1, 5, 1, 2, 1, 0, 8, 1, 0, 0, 1,  0, 0, 2, 0, 0},
      '{1, 1, 6, 1, 8, 1, 0, 9, 1, 0, 0, 0,  0, 1, 2, 0, 0},
      '{1, 1, 6, 1, 8, 1, 0, 9, 1, 0, 0, 0,  0, 1, 2, 0, 0},
      '{1, 1, 6, 1, 8, 1, 0, 9, 1, 0, 0, 0,  0, 1, 2, 0, 0},
      '{1, 1, 6, 1, 8, 1, 0, 9, 1, 0, 0, 1,  0, 0, 2, 1, 0},
      '{1, 1, 0, 0, 0, 0, 0, 3, 1, 1, 0, 1,  0, 0, 0, 0, 0},
      '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0},
      '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0},
      '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0},
      '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0},
      '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 1},
      '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 1},
      '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 1}
    };
    for (int i = 0; i < 37; i++) apply(tv[i], i);
    // reset while frozen in MEM_WAIT, then a load-use pair proves the FSM is back in RUN
    hs = '{
      '{1, 1, 0, 0, 0, 0, 0, 5, 1, 0, 0, 1,  0, 0, 0, 0, 1},
      '{1, 1, 5, 1, 0, 0, 0, 2, 1, 1, 0, 1,  0, 0, 1, 0, 1},
      '{1, 1, 5, 1, 0, 0, 0, 9, 1, 0, 0, 1,  0, 0, 2, 0, 1},
      '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 2, 0, 1},
      '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 2, 0, 1},
      '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0},
      '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0},
      '{1, 1, 0, 0, 0, 0, 0, 2, 1, 1, 0, 1,  0, 0, 0, 0, 0},
      '{1, 1, 2, 1, 0, 0, 0, 4, 1, 0, 0, 1,  1, 0, 0, 0, 0}
    };
    for (int i = 0; i < 9; i++) apply(hs[i], 100 + i);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/operand_fwd_ctrl.md
# operand_fwd_ctrl

Generates the registered 2-bit operand-select codes that drive the EX-stage `mux_4to1` operand selectors in the vector pipeline, plus the load-use stall and memory-wait freeze controls. It keeps a shadow copy of the destination-register state for the EX and MEM slots, updated in lock-step with the pipeline registers. It computes forwarding for the instruction in ID and registers the result so that the select is valid when that instruction reaches EX.

## Interface

Parameters:
- REG_W, 4, register-index width (16 vector registers; register 0 is hardwired zero and is never forwarded)
- TIMEOUT, 64, number of consecutive memory-wait cycles before `mem_timeout` is raised

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge
- rst_n  in  1  synchronous, active-low reset
- id_valid  in  1  ID holds a real instruction
- id_rs1, id_rs2  in  REG_W  source register indices
- id_rs1_used, id_rs2_used  in  1  source is actually read
- id_use_imm  in  1  operand B takes the immediate
- id_rd  in  REG_W  destination index
- id_wen  in  1  instruction writes `id_rd`
- id_is_load  in  1  instruction is a vector load
- flush  in  1  branch redirect; the ID instruction must not enter EX
- mem_ready  in  1  data memory has completed the access in MEM
- sel_a_ex  out  2  operand A select: 00 regfile, 01 EX/MEM fwd, 10 MEM/WB fwd (11 is never driven)
- sel_b_ex  out  2  operand B select: 00 regfile, 01 EX/MEM fwd, 10 MEM/WB fwd, 11 immediate
- stall_id  out  1  hold PC and IF/ID
- bubble_ex  out  1  load NOP into ID/EX
- freeze  out  1  hold every pipeline register
- mem_timeout  out  1  sticky error flag

## Operation

- Shadow slots EXs and MEMs each hold {v, rd, wen, ld}.
- Slots advance when `freeze`=0:
  - MEMs <= EXs.
  - EXs <= ID fields, but with v=0 if `bubble_ex`, `flush` or !`id_valid`.
- A producer P matches source rs when all of these hold: P.v, P.wen, P.rd==rs, rs!=0, and the corresponding rsX_used.
- Select per operand, in priority order:
  - imm (B only, code 11)
  - EXs match → 01
  - MEMs match → 10
  - otherwise 00
- Load-use hazard: EXs.ld=1 and EXs matches either used source, with `id_valid`=1.
- FSM states:
  - RUN:
    - MEMs.ld && MEMs.v && !mem_ready → MEM_WAIT (MEM_WAIT has priority).
    - Otherwise, on a load-use hazard with !flush → LU_STALL.
  - LU_STALL: lasts exactly 1 cycle. Next state is MEM_WAIT if the memory-wait condition holds, else RUN.
  - MEM_WAIT: exit to RUN on the cycle `mem_ready`=1.
- Outputs:
  - `stall_id` = `bubble_ex` = load-use hazard in RUN (combinational).
  - `freeze` = memory-wait condition (combinational, active in RUN or MEM_WAIT).
- `flush` together with a hazard: flush wins. No stall, and EXs becomes invalid.
- `freeze` together with a hazard: freeze wins. Nothing advances and the selects hold.
- Timeout counter:
  - Increments each cycle `freeze`=1 and clears when `freeze`=0.
  - Reaching TIMEOUT sets `mem_timeout`, which stays set until reset.
  - The counter saturates at TIMEOUT.

## Timing

- Reset (`rst_n`=0 at an edge):
  - Both slots invalid, state RUN.
  - `sel_a_ex`=`sel_b_ex`=00, `mem_timeout`=0, counter 0.
  - Combinational outputs are therefore 0.
- Reset mid-operation: takes effect on the next edge and discards all slots and pending stalls.
- Select latency: computed from ID in cycle N, visible on `sel_*_ex` in cycle N+1, when the instruction is in EX.
- `sel_*_ex` register updates:
  - Hold while `freeze`=1.
  - Load 00/00 when a bubble or flush is inserted.
- Load-use sequence (consumer immediately after load):
  - Cycle N: `stall_id`=1.
  - Cycle N+1: the consumer is re-evaluated with the load in MEMs and gets select 10 in cycle N+2.
- Minimum load-to-use penalty: 1 cycle. Each cycle of !mem_ready adds one frozen cycle.

## Test plan

- Back-to-back ALU: I1 writes r3, I2 reads r3 as rs1, then rs2 → `sel_a_ex`=01 for I2, then `sel_b_ex`=01; no stall.
- Distance 2: writer of r5, an independent instruction, then a reader of r5 → select 10. Writer to r0 followed by a reader of r0 → 00.
- Double match: EXs and MEMs both write r7, reader of r7 → 01 (newest wins). Reader with `id_use_imm`=1 → `sel_b_ex`=11 regardless of matches.
- Load-use: load r2, then add r2 → exactly one cycle of `stall_id`=`bubble_ex`=1, then the add's `sel_a_ex`=10. The same pair with `flush`=1 on the hazard cycle → no stall, EXs invalid.
- Memory wait: load in MEM with `mem_ready`=0 for 3 cycles → `freeze`=1 for 3 cycles and `sel_*_ex` unchanged. With TIMEOUT=4 and 4 wait cycles → `mem_timeout`=1 and it remains 1 after `mem_ready` returns.
- Reset asserted during MEM_WAIT → next cycle all outputs 0 and state RUN.
